// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
//   Shared definitions for the fetch-to-decode path: bundle width, lane-bit
//   meanings and the helper that turns a two-lane valid/take mask into a
//   slot count. Used by fetch_queue and by the f_stage / d_stage users.
package fetch_queue_pkg;

    // Width of one fetch/decode bundle.
    localparam int BUNDLE_W = 66;

    // Lane bit positions in two-bit valid/take masks.
    localparam int LANE_OLD   = 0;
    localparam int LANE_YOUNG = 1;

    typedef logic [1:0] lane_mask_t;

    // Number of slots a lane mask represents. Only 11 and 01 are meaningful;
    // a younger lane without the older one (10) counts as nothing.
    function automatic logic [1:0] slot_count(input lane_mask_t m);
        logic [1:0] n;
        n = 2'd0;
        if (m == 2'b11) begin
            n = 2'd2;
        end else if (m == 2'b01) begin
            n = 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
//   Two-in / two-out in-order queue between fetch and the two decode lanes.
//   A decode stall shows up as out_take=00; fetch is held off via in_ready.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high
//   flush      : synchronous discard of all entries (redirect)
//   in_valid   : fetch slot valids, bit0 = older slot
//   in_d0/d1   : fetch slot bundles
//   in_ready   : at least two entries free (registered state only)
//   out_valid  : decode lane valids, bit0 = oldest entry
//   out_d0/d1  : oldest / second-oldest entries, zero when not valid
//   out_take   : decode lanes consumed this cycle
//   count      : current occupancy
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = BUNDLE_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [1:0]                 in_valid,
    input  logic [W-1:0]               in_d0,
    input  logic [W-1:0]               in_d1,
    output logic                       in_ready,
    output logic [1:0]                 out_valid,
    output logic [W-1:0]               out_d0,
    output logic [W-1:0]               out_d1,
    input  logic [1:0]                 out_take,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_TWO    = CW'(2);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] READY_MAX  = CW'(DEPTH - 2);

    logic [W-1:0]  mem_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [1:0]    nwrite;
    logic [1:0]    nread;
    logic [PW-1:0] head_p1;
    logic [PW-1:0] tail_p1;

    assign head_p1 = head_q + PTR_ONE;
    assign tail_p1 = tail_q + PTR_ONE;

    assign in_ready                = (count_q <= READY_MAX);
    assign out_valid[LANE_OLD]     = (count_q != CNT_ZERO);
    assign out_valid[LANE_YOUNG]   = (count_q >= CNT_TWO);

    assign out_d0 = out_valid[LANE_OLD]   ? mem_q[head_q]  : '0;
    assign out_d1 = out_valid[LANE_YOUNG] ? mem_q[head_p1] : '0;

    assign count = count_q;

    // Masking the take with the valids folds all the "take beyond what is
    // visible" cases into the same 11/01/other decode used for writes.
    assign nwrite = in_ready ? slot_count(in_valid) : 2'd0;
    assign nread  = slot_count(out_take & out_valid);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(nread);
            tail_d  = tail_q + PW'(nwrite);
            count_d = count_q + CW'(nwrite) - CW'(nread);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset: nothing reads it while the entry is invalid.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (nwrite != 2'd0) begin
                mem_q[tail_q] <= in_d0;
            end
            if (nwrite == 2'd2) begin
                mem_q[tail_p1] <= in_d1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic          clk;
    logic          reset;
    logic          flush;
    logic [1:0]    in_valid;
    logic [65:0]   in_d0;
    logic [65:0]   in_d1;
    logic          in_ready;
    logic [1:0]    out_valid;
    logic [65:0]   out_d0;
    logic [65:0]   out_d1;
    logic [1:0]    out_take;
    logic [3:0]    count;

    int errors = 0;
    int checks = 0;

    fetch_queue #(.DEPTH(8), .W(66)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_d0     (in_d0),
        .in_d1     (in_d1),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_d0    (out_d0),
        .out_d1    (out_d1),
        .out_take  (out_take),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [65:0] mk(input int v);
        return {2'b11, 32'hC0DE0000, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] iv, input logic [65:0] d0,
                         input logic [65:0] d1, input logic [1:0] tk,
                         input logic fl);
        in_valid = iv;
        in_d0    = d0;
        in_d1    = d1;
        out_take = tk;
        flush    = fl;
    endtask

    task automatic idle();
        drive(2'b00, '0, '0, 2'b00, 1'b0);
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 00", out_valid);
        end
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", count);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if (out_d0 !== 66'd0 || out_d1 !== 66'd0) begin
            errors++;
            $display("FAIL reset_out_d: got %h %h want 0 0", out_d0, out_d1);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        drive(2'b11, mk(32'hA), mk(32'hB), 2'b00, 1'b0);
        tick();
        idle();
        checks++;
        if (out_valid !== 2'b11 || count !== 4'd2) begin
            errors++;
            $display("FAIL basic_valid_count: got %b/%0d want 11/2", out_valid, count);
        end
        checks++;
        if (out_d0 !== mk(32'hA) || out_d1 !== mk(32'hB)) begin
            errors++;
            $display("FAIL basic_data: got %h %h want %h %h", out_d0, out_d1, mk(32'hA), mk(32'hB));
        end
        drive(2'b00, '0, '0, 2'b11, 1'b0);
        tick();
        idle();
        checks++;
        if (count !== 4'd0 || out_valid !== 2'b00) begin
            errors++;
            $display("FAIL basic_drain: got %0d/%b want 0/00", count, out_valid);
        end
    endtask

    task automatic test_illegal_10();
        drive(2'b10, mk(32'h77), mk(32'h78), 2'b00, 1'b0);
        tick();
        idle();
        checks++;
        if (count !== 4'd0 || out_valid !== 2'b00) begin
            errors++;
            $display("FAIL illegal_10: got %0d/%b want 0/00", count, out_valid);
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, mk(100 + 2 * k), mk(101 + 2 * k), 2'b00, 1'b0);
            tick();
        end
        idle();
        checks++;
        if (count !== 4'd8 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: got %0d/%b want 8/0", count, in_ready);
        end
        drive(2'b11, mk(32'hBAD0), mk(32'hBAD1), 2'b00, 1'b0);
        tick();
        idle();
        checks++;
        if (count !== 4'd8) begin
            errors++;
            $display("FAIL full_write_blocked: got %0d want 8", count);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_d0 !== mk(100 + 2 * k) || out_d1 !== mk(101 + 2 * k)) begin
                errors++;
                $display("FAIL full_drain_%0d: got %h %h want %h %h", k, out_d0, out_d1,
                         mk(100 + 2 * k), mk(101 + 2 * k));
            end
            drive(2'b00, '0, '0, 2'b11, 1'b0);
            tick();
        end
        idle();
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL full_empty: got %0d want 0", count);
        end
    endtask

    task automatic test_count7();
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, mk(200 + 2 * k), mk(201 + 2 * k), 2'b00, 1'b0);
            tick();
        end
        drive(2'b01, mk(206), mk(32'hBAD2), 2'b00, 1'b0);
        tick();
        idle();
        checks++;
        if (count !== 4'd7 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL c7_state: got %0d/%b want 7/0", count, in_ready);
        end
        drive(2'b01, mk(32'hBAD3), '0, 2'b00, 1'b0);
        tick();
        idle();
        checks++;
        if (count !== 4'd7) begin
            errors++;
            $display("FAIL c7_write_blocked: got %0d want 7", count);
        end
        drive(2'b00, '0, '0, 2'b01, 1'b0);
        tick();
        idle();
        checks++;
        if (count !== 4'd6 || in_ready !== 1'b1 || out_d0 !== mk(201)) begin
            errors++;
            $display("FAIL c7_take01: got %0d/%b/%h want 6/1/%h", count, in_ready, out_d0, mk(201));
        end
        drive(2'b00, '0, '0, 2'b10, 1'b0);
        tick();
        idle();
        checks++;
        if (count !== 4'd6 || out_d0 !== mk(201)) begin
            errors++;
            $display("FAIL take10_ignored: got %0d/%h want 6/%h", count, out_d0, mk(201));
        end
        for (int k = 0; k < 3; k++) begin
            drive(2'b00, '0, '0, 2'b11, 1'b0);
            tick();
        end
        idle();
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL c7_empty: got %0d want 0", count);
        end
    endtask

    task automatic test_take_beyond();
        drive(2'b01, mk(300), '0, 2'b00, 1'b0);
        tick();
        drive(2'b00, '0, '0, 2'b11, 1'b0);
        checks++;
        if (out_valid !== 2'b01 || out_d1 !== 66'd0) begin
            errors++;
            $display("FAIL single_visible: got %b/%h want 01/0", out_valid, out_d1);
        end
        tick();
        idle();
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL take_beyond: got %0d want 0", count);
        end
    endtask

    task automatic test_wrap();
        drive(2'b11, mk(0), mk(1), 2'b00, 1'b0);
        tick();
        for (int i = 1; i < 20; i++) begin
            checks++;
            if (out_d0 !== mk(2 * i - 2) || out_d1 !== mk(2 * i - 1) || count !== 4'd2) begin
                errors++;
                $display("FAIL wrap_%0d: got %h %h c=%0d want %h %h c=2", i, out_d0, out_d1,
                         count, mk(2 * i - 2), mk(2 * i - 1));
            end
            drive(2'b11, mk(2 * i), mk(2 * i + 1), 2'b11, 1'b0);
            tick();
        end
        checks++;
        if (out_d0 !== mk(38) || out_d1 !== mk(39) || count !== 4'd2) begin
            errors++;
            $display("FAIL wrap_last: got %h %h c=%0d want %h %h c=2", out_d0, out_d1, count,
                     mk(38), mk(39));
        end
        drive(2'b00, '0, '0, 2'b11, 1'b0);
        tick();
        idle();
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL wrap_empty: got %0d want 0", count);
        end
    endtask

    task automatic test_flush();
        drive(2'b11, mk(400), mk(401), 2'b00, 1'b0);
        tick();
        drive(2'b11, mk(402), mk(403), 2'b00, 1'b0);
        tick();
        drive(2'b01, mk(404), '0, 2'b00, 1'b0);
        tick();
        idle();
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL flush_setup: got %0d want 5", count);
        end
        drive(2'b11, mk(32'hDEAD), mk(32'hDEAE), 2'b11, 1'b1);
        tick();
        idle();
        checks++;
        if (count !== 4'd0 || out_valid !== 2'b00 || out_d0 !== 66'd0) begin
            errors++;
            $display("FAIL flush_clear: got %0d/%b/%h want 0/00/0", count, out_valid, out_d0);
        end
        drive(2'b01, mk(32'hE), '0, 2'b00, 1'b0);
        tick();
        idle();
        checks++;
        if (out_valid !== 2'b01 || out_d0 !== mk(32'hE) || out_d1 !== 66'd0) begin
            errors++;
            $display("FAIL flush_after: got %b/%h/%h want 01/%h/0", out_valid, out_d0, out_d1, mk(32'hE));
        end
        drive(2'b00, '0, '0, 2'b01, 1'b0);
        tick();
        idle();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, mk(500 + 2 * k), mk(501 + 2 * k), 2'b00, 1'b0);
            tick();
        end
        idle();
        checks++;
        if (count !== 4'd6) begin
            errors++;
            $display("FAIL areset_setup: got %0d want 6", count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 2'b00 || count !== 4'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_immediate: got %b/%0d/%b want 00/0/1", out_valid, count, in_ready);
        end
        reset = 1'b0;
        drive(2'b01, mk(32'hC), '0, 2'b00, 1'b0);
        tick();
        idle();
        checks++;
        if (out_d0 !== mk(32'hC) || count !== 4'd1 || out_valid !== 2'b01) begin
            errors++;
            $display("FAIL areset_resume: got %h/%0d/%b want %h/1/01", out_d0, count, out_valid, mk(32'hC));
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #12;
        test_reset();
        test_basic();
        test_illegal_10();
        test_full();
        test_count7();
        test_take_beyond();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of entries (power of two, at least 4).
REQ-002 SHALL have parameter W, default 66, meaning entry width (same packing as the decode-lane input bundle).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1, meaning synchronous discard of all entries (branch mispredict redirect).
REQ-006 SHALL have port in_valid, input, 2, meaning fetch slot valids; bit0 = older slot.
REQ-007 SHALL have ports in_d0 and in_d1, input, W each, meaning fetch slot 0 and slot 1 bundles.
REQ-008 SHALL have port in_ready, output, 1, meaning at least 2 entries free.
REQ-009 SHALL have port out_valid, output, 2, meaning decode lane valids; bit0 = oldest entry.
REQ-010 SHALL have ports out_d0 and out_d1, output, W each, meaning the oldest and second-oldest entries.
REQ-011 SHALL have port out_take, input, 2, meaning decode lanes consumed entries this cycle.
REQ-012 SHALL have port count, output, log2(DEPTH)+1, meaning current occupancy.

Function
REQ-013 SHALL store entries in order, with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-014 SHALL drive in_ready = (DEPTH - count >= 2), derived from registered state only.
REQ-015 SHALL accept a write only when in_ready=1; nwrite = 2 for in_valid 11, 1 for 01, 0 otherwise (10 is illegal and is treated as 00).
REQ-016 SHALL write in_d0 at tail and in_d1 at tail+1 (mod DEPTH), then advance tail by nwrite.
REQ-017 SHALL drive out_valid[0] = (count>=1) and out_valid[1] = (count>=2) from registered count; there is no same-cycle bypass, so write-to-visible latency is 1 cycle.
REQ-018 SHALL drive out_d0 = entry[head] and out_d1 = entry[head+1] combinationally, and drive each as zero when its valid bit is 0.
REQ-019 SHALL compute nread = 2 for out_take 11 with out_valid 11, 1 for out_take x1 with out_valid[0]=1, and 0 otherwise; any take beyond out_valid, or out_take 10, is ignored.
REQ-020 SHALL advance head by nread and update count <= count + nwrite - nread in the same edge; a simultaneous read and write at full or empty is legal.
REQ-021 SHALL give flush priority over all reads and writes in the same cycle: head, tail and count clear to 0, and that cycle's writes are dropped.
REQ-022 SHALL never let count exceed DEPTH and never let it underflow; this is guaranteed by REQ-014 and REQ-019.

Reset
REQ-023 SHALL, on reset assertion, immediately clear head, tail and count to 0, making out_valid=00, out_d0=out_d1=0 and in_ready=1, including when reset arrives mid-operation.
REQ-024 SHALL NOT require entry storage to be reset; storage is never observable while invalid.
REQ-025 SHALL resume accepting writes on the first clk edge after reset deasserts.

Structure
REQ-026 SHALL keep the bundle width constant (66) and the lane-bit meanings in the shared core package, together with d_stage and f_stage users.
REQ-027 SHALL be a single module with no sub-modules; pointer and count logic stays inline and storage is a register array.
REQ-028 SHALL be placed between f_stage output and the two d_stage inputs, so that a decode stall backpressures through out_take=00 rather than through stall_f.

Verification
REQ-029 Reset then write in_valid=11 with d0=A, d1=B -> next cycle out_valid=11, out_d0=A, out_d1=B, count=2.
REQ-030 Fill with 4 pairs (DEPTH=8) -> count=8, in_ready=0; in_valid=11 presented while full -> no change, and no data is lost.
REQ-031 count=7 -> in_ready=0 (only 1 entry free); take 01 -> count=6, in_ready=1 next cycle.
REQ-032 Wrap-around: sustain 20 cycles of write 11 / take 11 with sequence 0..39 -> outputs appear in exact order 0..39 and count stays at 2.
REQ-033 count=5 with flush=1, in_valid=11 and out_take=11 all in the same cycle -> count=0, out_valid=00 next cycle, and the written data never appears.
REQ-034 Assert reset asynchronously mid-cycle at count=6 -> out_valid=00 and count=0 before the next clk edge; then write 01 with C -> out_d0=C.
